// File: rtl/alu.sv
// Registered 32-bit ALU for the execute stage: nine ops selected by a 4-bit
// opcode, with zero and carry flags captured alongside the result.
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic [3:0]  aluOp,
    input  logic        shiftAmount,
    output logic [31:0] res,
    output logic        zeroFlag,
    output logic        carryFlag
);

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_XOR = 4'b0100,
        OP_NOT = 4'b0101,
        OP_SLA = 4'b0110,
        OP_SRA = 4'b0111,
        OP_SRL = 4'b1000
    } op_e;

    logic [31:0] res_d, res_q;
    logic        zero_d, zero_q;
    logic        carry_d, carry_q;

    logic [31:0] addend;
    logic [32:0] sum;
    logic        is_sub;

    // ADD and SUB share one adder; SUB is A + ~B + 1, so carry-out means no borrow.
    always_comb begin
        is_sub = (aluOp == OP_SUB);
        addend = is_sub ? ~operandB : operandB;
        sum    = {1'b0, operandA} + {1'b0, addend} + {32'd0, is_sub};
    end

    always_comb begin
        res_d   = 32'd0;
        carry_d = 1'b0;
        case (op_e'(aluOp))
            OP_ADD, OP_SUB: begin
                res_d   = sum[31:0];
                carry_d = sum[32];
            end
            OP_AND: res_d = operandA & operandB;
            OP_OR:  res_d = operandA | operandB;
            OP_XOR: res_d = operandA ^ operandB;
            OP_NOT: res_d = ~operandA;
            OP_SLA: begin
                res_d   = shiftAmount ? {operandA[30:0], 1'b0} : operandA;
                carry_d = shiftAmount & operandA[31];
            end
            OP_SRA: begin
                res_d   = shiftAmount ? {operandA[31], operandA[31:1]} : operandA;
                carry_d = shiftAmount & operandA[0];
            end
            OP_SRL: begin
                res_d   = shiftAmount ? {1'b0, operandA[31:1]} : operandA;
                carry_d = shiftAmount & operandA[0];
            end
            default: begin
                res_d   = 32'd0;
                carry_d = 1'b0;
            end
        endcase
        zero_d = (res_d == 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= 32'd0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign res       = res_q;
    assign zeroFlag  = zero_q;
    assign carryFlag = carry_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU; expected values are hand-computed.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [3:0]  aluOp;
    logic        shiftAmount;
    logic [31:0] res;
    logic        zeroFlag;
    logic        carryFlag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sh;
        logic [31:0] r;
        logic        z;
        logic        c;
    } vec_t;

    alu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .operandA   (operandA),
        .operandB   (operandB),
        .aluOp      (aluOp),
        .shiftAmount(shiftAmount),
        .res        (res),
        .zeroFlag   (zeroFlag),
        .carryFlag  (carryFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one vector, then sample 1 ns after the capturing edge.
    task automatic drive(input vec_t v);
        operandA    = v.a;
        operandB    = v.b;
        aluOp       = v.op;
        shiftAmount = v.sh;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t v;
        rst_n = 1'b0;
        operandA = 32'd0; operandB = 32'd0; aluOp = 4'd0; shiftAmount = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (res !== 32'd0 || zeroFlag !== 1'b1 || carryFlag !== 1'b0) begin
            bad++;
            $display("FAIL reset_initial: got res=%h z=%b c=%b want res=0 z=1 c=0", res, zeroFlag, carryFlag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // 0xFFFFFFFF + 2 -> res 1, carry 1
        v = '{4'b0000, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd1, 1'b0, 1'b1};
        drive(v);
        total++;
        if (res !== v.r || zeroFlag !== v.z || carryFlag !== v.c) begin
            bad++;
            $display("FAIL reset_preload: got res=%h z=%b c=%b want res=%h z=%b c=%b", res, zeroFlag, carryFlag, v.r, v.z, v.c);
        end
        // Async assert 3 ns after an edge, well before the next one.
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (res !== 32'd0 || zeroFlag !== 1'b1 || carryFlag !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got res=%h z=%b c=%b want res=0 z=1 c=0", res, zeroFlag, carryFlag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        v = '{4'b0000, 32'd30, 32'd10, 1'b0, 32'd40, 1'b0, 1'b0};
        drive(v);
        total++;
        if (res !== v.r || zeroFlag !== v.z || carryFlag !== v.c) begin
            bad++;
            $display("FAIL reset_release: got res=%h z=%b c=%b want res=%h z=%b c=%b", res, zeroFlag, carryFlag, v.r, v.z, v.c);
        end
    endtask

    task automatic test_addsub();
        vec_t v[4];
        v[0] = '{4'b0000, 32'd30,         32'd10, 1'b0, 32'd40,         1'b0, 1'b0};
        v[1] = '{4'b0001, 32'd30,         32'd10, 1'b0, 32'd20,         1'b0, 1'b1};
        v[2] = '{4'b0001, 32'd10,         32'd30, 1'b0, 32'hFFFF_FFEC,  1'b0, 1'b0};
        v[3] = '{4'b0000, 32'hFFFF_FFFF,  32'd1,  1'b0, 32'd0,          1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(v[i]);
            total++;
            if (res !== v[i].r || zeroFlag !== v[i].z || carryFlag !== v[i].c) begin
                bad++;
                $display("FAIL addsub[%0d]: got res=%h z=%b c=%b want res=%h z=%b c=%b", i, res, zeroFlag, carryFlag, v[i].r, v[i].z, v[i].c);
            end
        end
    endtask

    task automatic test_logic();
        vec_t v[5];
        v[0] = '{4'b0010, 32'd14,        32'd3,  1'b1, 32'd2,  1'b0, 1'b0};
        v[1] = '{4'b0011, 32'd14,        32'd3,  1'b1, 32'd15, 1'b0, 1'b0};
        v[2] = '{4'b0100, 32'd14,        32'd3,  1'b1, 32'd13, 1'b0, 1'b0};
        v[3] = '{4'b0101, 32'hFFFF_FFF0, 32'd3,  1'b1, 32'd15, 1'b0, 1'b0};
        v[4] = '{4'b0010, 32'hF0F0_0000, 32'h0F0F_FFFF, 1'b0, 32'd0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(v[i]);
            total++;
            if (res !== v[i].r || zeroFlag !== v[i].z || carryFlag !== v[i].c) begin
                bad++;
                $display("FAIL logic[%0d]: got res=%h z=%b c=%b want res=%h z=%b c=%b", i, res, zeroFlag, carryFlag, v[i].r, v[i].z, v[i].c);
            end
        end
    endtask

    task automatic test_shift();
        vec_t v[9];
        v[0] = '{4'b0110, 32'd7,          32'hDEAD_BEEF, 1'b1, 32'd14,         1'b0, 1'b0};
        v[1] = '{4'b0111, 32'hFFFF_FFFE,  32'hDEAD_BEEF, 1'b1, 32'hFFFF_FFFF,  1'b0, 1'b0};
        v[2] = '{4'b1000, 32'd14,         32'hDEAD_BEEF, 1'b1, 32'd7,          1'b0, 1'b0};
        v[3] = '{4'b1000, 32'h8000_0001,  32'hDEAD_BEEF, 1'b1, 32'h4000_0000,  1'b0, 1'b1};
        v[4] = '{4'b0110, 32'h8000_0000,  32'hDEAD_BEEF, 1'b1, 32'd0,          1'b1, 1'b1};
        v[5] = '{4'b0111, 32'h8000_0001,  32'd0,         1'b1, 32'hC000_0000,  1'b0, 1'b1};
        v[6] = '{4'b0111, 32'h8000_0000,  32'd0,         1'b0, 32'h8000_0000,  1'b0, 1'b0};
        v[7] = '{4'b0110, 32'h8000_0001,  32'd0,         1'b0, 32'h8000_0001,  1'b0, 1'b0};
        v[8] = '{4'b1000, 32'h8000_0001,  32'd0,         1'b0, 32'h8000_0001,  1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            drive(v[i]);
            total++;
            if (res !== v[i].r || zeroFlag !== v[i].z || carryFlag !== v[i].c) begin
                bad++;
                $display("FAIL shift[%0d]: got res=%h z=%b c=%b want res=%h z=%b c=%b", i, res, zeroFlag, carryFlag, v[i].r, v[i].z, v[i].c);
            end
        end
    endtask

    task automatic test_reserved();
        vec_t v[3];
        v[0] = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b1, 1'b0};
        v[1] = '{4'b0000, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'd3, 1'b0, 1'b0};
        v[2] = '{4'b1001, 32'hFFFF_FFFF, 32'd1,         1'b1, 32'd0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(v[i]);
            total++;
            if (res !== v[i].r || zeroFlag !== v[i].z || carryFlag !== v[i].c) begin
                bad++;
                $display("FAIL reserved[%0d]: got res=%h z=%b c=%b want res=%h z=%b c=%b", i, res, zeroFlag, carryFlag, v[i].r, v[i].z, v[i].c);
            end
        end
    endtask

    // Opcode changes every cycle; each sample must reflect only the previous edge's inputs.
    task automatic test_back_to_back();
        vec_t v[9];
        v[0] = '{4'b0000, 32'h8000_0003, 32'd5, 1'b1, 32'h8000_0008, 1'b0, 1'b0};
        v[1] = '{4'b0001, 32'h8000_0003, 32'd5, 1'b1, 32'h7FFF_FFFE, 1'b0, 1'b1};
        v[2] = '{4'b0010, 32'h8000_0003, 32'd5, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        v[3] = '{4'b0011, 32'h8000_0003, 32'd5, 1'b1, 32'h8000_0007, 1'b0, 1'b0};
        v[4] = '{4'b0100, 32'h8000_0003, 32'd5, 1'b1, 32'h8000_0006, 1'b0, 1'b0};
        v[5] = '{4'b0101, 32'h8000_0003, 32'd5, 1'b1, 32'h7FFF_FFFC, 1'b0, 1'b0};
        v[6] = '{4'b0110, 32'h8000_0003, 32'd5, 1'b1, 32'h0000_0006, 1'b0, 1'b1};
        v[7] = '{4'b0111, 32'h8000_0003, 32'd5, 1'b1, 32'hC000_0001, 1'b0, 1'b1};
        v[8] = '{4'b1000, 32'h8000_0003, 32'd5, 1'b1, 32'h4000_0001, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            drive(v[i]);
            total++;
            if (res !== v[i].r || zeroFlag !== v[i].z || carryFlag !== v[i].c) begin
                bad++;
                $display("FAIL b2b[%0d]: got res=%h z=%b c=%b want res=%h z=%b c=%b", i, res, zeroFlag, carryFlag, v[i].r, v[i].z, v[i].c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_logic();
        test_shift();
        test_reserved();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
